// File: rtl/image_parallel_processing_irq_aggregator.sv
// image_parallel_processing_irq_aggregator: Avalon-MM interrupt aggregator with
// pending/mask registers, priority vector and a saturating source-0 event counter.
// Ports: clk/reset_n (async active-low); address/chipselect/write_n/writedata slave
// write side; readdata registered read data (1-cycle latency); irq_in raw requests;
// irq combined masked interrupt to the CPU.
module image_parallel_processing_irq_aggregator #(
  parameter int NUM_SRC = 8,
  parameter logic [15:0] EDGE_MASK = 16'h0001,
  parameter int CNT_WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [2:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [15:0]        writedata,
  input  logic [NUM_SRC-1:0] irq_in,
  output logic [15:0]        readdata,
  output logic               irq
);
  localparam logic [NUM_SRC-1:0] EM = EDGE_MASK[NUM_SRC-1:0];
  logic [NUM_SRC-1:0] s_q, s_d, pending, mask, rise, act, clr, pend_nxt;
  logic [CNT_WIDTH-1:0] cnt;
  logic [3:0] vec_idx;
  logic vec_valid, wr;
  logic [15:0] rd_mux;
  assign wr = chipselect & ~write_n;
  assign rise = s_q & ~s_d;
  assign act = pending & mask;
  assign clr = (wr && address == 3'd1) ? writedata[NUM_SRC-1:0] : '0;
  // Edge sources keep state until W1C (a same-cycle rise wins); level sources mirror s_q.
  assign pend_nxt = (EM & ((pending & ~clr) | rise)) | (~EM & s_q);
  // Scan from the top down so the lowest-index active source ends up in vec_idx.
  always_comb begin
    vec_idx = '0;
    vec_valid = |act;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (act[i]) vec_idx = 4'(i);
  end
  always_comb begin
    rd_mux = address == 3'd0 ? 16'(act) :
             address == 3'd1 ? 16'(pending) :
             address == 3'd2 ? 16'(mask) :
             address == 3'd3 ? 16'(s_q) :
             address == 3'd4 ? {vec_valid, 11'b0, vec_idx} :
             address == 3'd5 ? 16'(cnt) : 16'h0000;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_q <= '0;
      s_d <= '0;
      pending <= '0;
      mask <= '0;
      cnt <= '0;
      irq <= 1'b0;
      readdata <= '0;
    end else begin
      s_q <= irq_in;
      s_d <= s_q;
      pending <= pend_nxt;
      if (wr && address == 3'd2) mask <= writedata[NUM_SRC-1:0];
      // Clear wins over a same-cycle increment; count stops at all-ones.
      if (wr && address == 3'd5) cnt <= '0;
      else if (rise[0] && cnt != '1) cnt <= cnt + 1'b1;
      irq <= |act;
      readdata <= rd_mux;
    end
  end
endmodule

// File: tb/tb_image_parallel_processing_irq_aggregator.sv
// tb_image_parallel_processing_irq_aggregator: directed self-checking bench.
module tb_image_parallel_processing_irq_aggregator;
  logic clk = 0, reset_n = 0, chipselect = 0, write_n = 1;
  logic [2:0] address = 0;
  logic [15:0] writedata = 0, readdata, r;
  logic [7:0] irq_in = 0;
  logic irq;
  int checks = 0, errors = 0;
  image_parallel_processing_irq_aggregator #(.NUM_SRC(8), .EDGE_MASK(16'h0029), .CNT_WIDTH(10)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .irq_in(irq_in), .readdata(readdata), .irq(irq));
  always #5 clk = ~clk;
  task automatic rd(input logic [2:0] a, output logic [15:0] d);
    @(negedge clk);
    address = a; chipselect = 0; write_n = 1;
    @(negedge clk);
    d = readdata;
  endtask
  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    address = a; chipselect = 1; write_n = 0; writedata = d;
    @(negedge clk);
    chipselect = 0; write_n = 1;
  endtask
  task automatic test_reset;
    #12;
    checks++; if (readdata !== 16'h0 || irq !== 1'b0) begin errors++; $display("FAIL reset_hold rd=%h irq=%b exp 0", readdata, irq); end
    @(negedge clk); reset_n = 1;
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), r);
      checks++; if (r !== 16'h0) begin errors++; $display("FAIL reset_read a=%0d got %h exp 0000", a, r); end
    end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", irq); end
  endtask
  task automatic test_edge;
    wr(2, 16'h0001);
    @(negedge clk); irq_in[0] = 1;
    @(negedge clk); irq_in[0] = 0;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL edge_e1 got %b exp 0", irq); end
    @(negedge clk);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL edge_e2 got %b exp 0", irq); end
    @(negedge clk);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL edge_e3 got %b exp 1", irq); end
    rd(4, r);
    checks++; if (r !== 16'h8000) begin errors++; $display("FAIL edge_vector got %h exp 8000", r); end
    rd(1, r);
    checks++; if (r !== 16'h0001) begin errors++; $display("FAIL edge_pending got %h exp 0001", r); end
    wr(1, 16'h0001);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL w1c_ew got %b exp 1", irq); end
    @(negedge clk);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL w1c_ew1 got %b exp 0", irq); end
  endtask
  task automatic test_level;
    wr(2, 16'h0004);
    @(negedge clk); irq_in[2] = 1;
    repeat (2) @(negedge clk);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL level_e2 got %b exp 0", irq); end
    @(negedge clk);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL level_e3 got %b exp 1", irq); end
    wr(1, 16'h0004);
    repeat (3) @(negedge clk);
    rd(1, r);
    checks++; if (r !== 16'h0004) begin errors++; $display("FAIL level_w1c got %h exp 0004", r); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL level_hold got %b exp 1", irq); end
    irq_in[2] = 0;
    repeat (2) @(negedge clk);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL level_fall2 got %b exp 1", irq); end
    @(negedge clk);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL level_fall3 got %b exp 0", irq); end
    rd(1, r);
    checks++; if (r !== 16'h0000) begin errors++; $display("FAIL level_pend_low got %h exp 0000", r); end
  endtask
  task automatic test_vector;
    wr(2, 16'h0028);
    @(negedge clk); irq_in = 8'h28;
    @(negedge clk); irq_in = 8'h00;
    repeat (3) @(negedge clk);
    rd(4, r);
    checks++; if (r !== 16'h8003) begin errors++; $display("FAIL vec_3 got %h exp 8003", r); end
    rd(0, r);
    checks++; if (r !== 16'h0028) begin errors++; $display("FAIL status got %h exp 0028", r); end
    wr(1, 16'h0008);
    rd(4, r);
    checks++; if (r !== 16'h8005) begin errors++; $display("FAIL vec_5 got %h exp 8005", r); end
    wr(1, 16'h0008);
    wr(2, 16'h0000);
    rd(4, r);
    checks++; if (r !== 16'h0000) begin errors++; $display("FAIL vec_masked got %h exp 0000", r); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL vec_irq got %b exp 0", irq); end
    wr(2, 16'h0028);
    wr(2, 16'h0000);
    rd(1, r);
    checks++; if (r !== 16'h0020) begin errors++; $display("FAIL vec_pending got %h exp 0020", r); end
    wr(1, 16'h0020);
    wr(2, 16'hFF00);
    rd(2, r);
    checks++; if (r !== 16'h0000) begin errors++; $display("FAIL mask_high_bits got %h exp 0000", r); end
  endtask
  task automatic test_raw;
    @(negedge clk); irq_in[4] = 1;
    rd(3, r);
    checks++; if (r !== 16'h0010) begin errors++; $display("FAIL raw got %h exp 0010", r); end
    irq_in[4] = 0;
    repeat (3) @(negedge clk);
  endtask
  task automatic test_same_cycle;
    wr(1, 16'h0001);
    @(negedge clk); irq_in[0] = 1;
    @(negedge clk); address = 1; chipselect = 1; write_n = 0; writedata = 16'h0001;
    @(negedge clk); chipselect = 0; write_n = 1; irq_in[0] = 0;
    rd(1, r);
    checks++; if (r !== 16'h0001) begin errors++; $display("FAIL rise_vs_w1c got %h exp 0001", r); end
    rd(5, r);
    checks++; if (r === 16'h0000) begin errors++; $display("FAIL evcount_nonzero got %h exp nonzero", r); end
    @(negedge clk); irq_in[0] = 1;
    @(negedge clk); address = 5; chipselect = 1; write_n = 0; writedata = 16'h0000;
    @(negedge clk); chipselect = 0; write_n = 1; irq_in[0] = 0;
    rd(5, r);
    checks++; if (r !== 16'h0000) begin errors++; $display("FAIL rise_vs_clear got %h exp 0000", r); end
  endtask
  task automatic test_saturate;
    for (int n = 0; n < 1030; n++) begin
      @(negedge clk); irq_in[0] = 1;
      @(negedge clk); irq_in[0] = 0;
    end
    repeat (2) @(negedge clk);
    rd(5, r);
    checks++; if (r !== 16'h03FF) begin errors++; $display("FAIL evcount_sat got %h exp 03ff", r); end
    wr(5, 16'h1234);
    rd(5, r);
    checks++; if (r !== 16'h0000) begin errors++; $display("FAIL evcount_clear got %h exp 0000", r); end
  endtask
  task automatic test_async_reset;
    wr(2, 16'h00FF);
    repeat (4) begin
      @(negedge clk); irq_in[0] = 1;
      @(negedge clk); irq_in[0] = 0;
    end
    @(negedge clk); irq_in[0] = 1; address = 1;
    repeat (2) @(negedge clk);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL pre_reset_irq got %b exp 1", irq); end
    #2 reset_n = 0;
    #1;
    checks++; if (readdata !== 16'h0 || irq !== 1'b0) begin errors++; $display("FAIL async_reset rd=%h irq=%b exp 0", readdata, irq); end
    irq_in = 0;
    @(negedge clk); reset_n = 1;
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), r);
      checks++; if (r !== 16'h0) begin errors++; $display("FAIL post_reset a=%0d got %h exp 0000", a, r); end
    end
  endtask
  initial begin
    test_reset;
    test_edge;
    test_level;
    test_vector;
    test_raw;
    test_same_cycle;
    test_saturate;
    test_async_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
